arith_exec_unit: RTL and testbench
==================================

# arith_exec_unit

Parametrised, pipelined arithmetic execute unit for the RISC-V core; successor to the single-cycle arithmetic functional unit. Takes issued ALU, writeback-select and jump-target operands through a valid/ready handshake and returns tagged results on a writeback port after a configurable number of register stages. Optionally adds an iterative RV32M/RV64M multiplier, with the issue port stalled while it runs. Supports pipeline flush on branch mispredict or exception.

## Interface
- XLEN, 32, datapath width; 32 or 64
- STAGES, 1, output register stages for single-cycle ops; 1..4
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- issue_valid  in  1  op presented
- issue_ready  out  1  unit accepts op this cycle
- aluop  in  4  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14–15 undefined
- w_src  in  2  0 CSR, 1 ALU_SRC, 2/3 register-file passthrough
- port_a, port_b  in  XLEN  ALU operands
- csr_rdata, reg_file_wdata  in  XLEN  alternate writeback sources
- rd  in  5  destination tag
- j_sel  in  1  1: JAL target, 0: JALR target
- pc, imm_UJ_ext, imm_I_ext  in  XLEN  jump operands
- flush  in  1  kill all in-flight work
- wb_valid  out  1  result valid, one-cycle pulse per op
- wb_rd  out  5  tag of result
- wb_data  out  XLEN  selected writeback value
- wb_target  out  XLEN  jump target of the same op
- illegal  out  1  undefined or unsupported aluop, qualified by wb_valid

## Operation
- Accept when issue_valid && issue_ready. issue_ready = !RST && !flush && !mul_busy.
- Writeback has no back-pressure; every accepted, unflushed op produces exactly one wb_valid.
- Shifts use port_b[log2(XLEN)-1:0]. SRA is arithmetic. SLT/SLTU return 1 or 0, zero-extended. ADD/SUB wrap modulo 2^XLEN.
- wb_data: w_src=0 gives csr_rdata; w_src=1 gives the ALU/MUL result; otherwise reg_file_wdata. All values are captured at accept.
- wb_target: j_sel=1 gives pc+imm_UJ_ext; j_sel=0 gives (port_a+imm_I_ext) with bit 0 cleared. Computed for every op.
- Multiplier FSM:
  - IDLE → RUN on accepting aluop 10–13.
  - RUN does one partial-product bit per cycle for XLEN cycles, then → DONE.
  - DONE drives the result for one cycle, then → IDLE.
  - MUL returns product[XLEN-1:0]. MULH returns the high half of the signed×signed product, MULHSU the high half of signed a × unsigned b, MULHU the high half of unsigned×unsigned. All match the exact 2·XLEN-bit product.
- Undefined aluop: single-cycle path, wb_data per w_src with ALU result 0, illegal=1.
- flush (synchronous): clears every pipeline valid bit, aborts the multiplier to IDLE, and suppresses wb_valid that cycle. An issue in the same cycle is not accepted.
- Reset: wb_valid=0, wb_rd=0, wb_data=0, wb_target=0, illegal=0, FSM=IDLE, issue_ready=0 while RST is high and 1 in the first cycle after release.

## Timing
- Single-cycle ops accepted at cycle T: wb_valid at T+STAGES. Full throughput, one op per cycle.
- Multiply accepted at T:
  - issue_ready=0 for cycles T+1..T+XLEN.
  - wb_valid at T+XLEN+1, and issue_ready=1 in that same cycle.
- No writeback collisions:
  - Ops already in flight at T drain by T+STAGES-1 < T+XLEN+1.
  - Ops accepted at ≥T+XLEN+1 return at ≥T+XLEN+1+STAGES.
- flush at cycle F: no wb_valid at F or later for ops accepted before F. issue_ready=1 at F+1.
- RST asserted mid-multiply: the result is discarded and the unit is idle after release.

## Configuration
- ARITH_EXEC_MUL_EN defined: multiplier FSM is present, and aluop 10–13 follow the multiply timing above.
- ARITH_EXEC_MUL_EN undefined: no multiplier logic. aluop 10–13 take the single-cycle path with ALU result 0 and illegal=1. issue_ready never drops except on RST or flush.

## Test plan
- STAGES=2, ADD 0x7FFFFFFF+0x1, rd=5, issued at cycle 0 → wb_valid at cycle 2, wb_data=0x80000000, wb_rd=5, illegal=0.
- Back-to-back issue: SRA 0x80000000 by 4, SLTU 1 vs 0xFFFFFFFF, SUB 0 − 1 → three consecutive wb_valid pulses with wb_data 0xF8000000, 0x00000001, 0xFFFFFFFF.
- MUL enabled, a=b=0xFFFFFFFF:
  - MUL → 0x00000001, MULH → 0x00000000, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF.
  - Each returns 33 cycles after accept, with issue_ready low for 32 cycles.
- MULHU in flight, flush at cycle 10 after accept → no wb_valid for that op, issue_ready=1 the next cycle, and a following ADD returns normally.
- Jump targets:
  - j_sel=0, port_a=0x1003, imm_I_ext=0x4 → wb_target=0x1006.
  - j_sel=1, pc=0x100, imm_UJ_ext=0xFFFFFFF0 → wb_target=0x000000F0.
  - w_src=0 with csr_rdata=0xABCD → wb_data=0xABCD.
- Macro undefined: MUL issued → wb_valid after STAGES cycles with illegal=1, wb_data=0, and issue_ready stays 1. aluop=15 → illegal=1 in both builds.

Source files
------------

// File: rtl/arith_exec_unit_if.sv
// ---------------------------------------------------------------------------
// arith_exec_unit_if
// Issue / writeback bus of the arithmetic execute unit.
//   issue side : issue_valid, issue_ready, aluop, w_src, port_a, port_b,
//                csr_rdata, reg_file_wdata, rd, j_sel, pc, imm_UJ_ext,
//                imm_I_ext, flush
//   writeback  : wb_valid, wb_rd, wb_data, wb_target, illegal
// master = issuing pipeline, slave = arith_exec_unit.
// ---------------------------------------------------------------------------
interface arith_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic            issue_ready;
  logic [3:0]      aluop;
  logic [1:0]      w_src;
  logic [XLEN-1:0] port_a;
  logic [XLEN-1:0] port_b;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] reg_file_wdata;
  logic [4:0]      rd;
  logic            j_sel;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm_UJ_ext;
  logic [XLEN-1:0] imm_I_ext;
  logic            flush;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] wb_target;
  logic            illegal;

  modport master (
    output issue_valid, aluop, w_src, port_a, port_b, csr_rdata,
           reg_file_wdata, rd, j_sel, pc, imm_UJ_ext, imm_I_ext, flush,
    input  issue_ready, wb_valid, wb_rd, wb_data, wb_target, illegal
  );

  modport slave (
    input  issue_valid, aluop, w_src, port_a, port_b, csr_rdata,
           reg_file_wdata, rd, j_sel, pc, imm_UJ_ext, imm_I_ext, flush,
    output issue_ready, wb_valid, wb_rd, wb_data, wb_target, illegal
  );
endinterface

// File: rtl/arith_exec_unit.sv
// ---------------------------------------------------------------------------
// arith_exec_unit
// Pipelined arithmetic execute unit. Single-cycle ALU ops, writeback-source
// selection and jump-target computation flow through STAGES register stages;
// the last stage drives the writeback port. An optional iterative multiplier
// (build macro ARITH_EXEC_MUL_EN) handles aluop 10..13 in XLEN cycles while
// the issue port is stalled, and injects its result into the last stage.
//
// Ports:
//   CLK  - clock
//   RST  - synchronous active-high reset
//   bus  - arith_exec_unit_if.slave (issue handshake, operands, flush,
//          writeback result)
//
// Parameters: XLEN (32 or 64), STAGES (1..4).
// ---------------------------------------------------------------------------
module arith_exec_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  arith_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic                   w_ready;
  logic                   w_acc;
  logic                   w_is_mul;
  logic                   w_ill;
  logic                   w_mul_busy;
  logic                   w_mul_done;
  logic [XLEN-1:0]        w_alu;
  logic [XLEN-1:0]        w_wbsel;
  logic [XLEN-1:0]        w_target;
  logic [XLEN-1:0]        w_jalr_sum;
  logic [XLEN-1:0]        w_mul_wb;
  logic [XLEN-1:0]        w_mul_tgt;
  logic [4:0]             w_mul_rd;
  logic [SHW-1:0]         w_shamt;
  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic signed [XLEN-1:0] w_sra;

  logic                   r_vld_p  [STAGES];
  logic [4:0]             r_rd_p   [STAGES];
  logic [XLEN-1:0]        r_data_p [STAGES];
  logic [XLEN-1:0]        r_tgt_p  [STAGES];
  logic                   r_ill_p  [STAGES];

  assign w_ready = !RST && !bus.flush && !w_mul_busy;
  assign w_acc   = bus.issue_valid && w_ready;

  // ---- issue: operand decode and single-cycle ALU ----
  assign w_shamt = bus.port_b[SHW-1:0];
  assign w_a_s   = bus.port_a;
  assign w_b_s   = bus.port_b;
  assign w_sra   = w_a_s >>> w_shamt;

  always_comb begin
    w_alu    = '0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (bus.aluop)
      4'd0:  w_alu = bus.port_a + bus.port_b;
      4'd1:  w_alu = bus.port_a - bus.port_b;
      4'd2:  w_alu = bus.port_a << w_shamt;
      4'd3:  w_alu = bus.port_a >> w_shamt;
      4'd4:  w_alu = w_sra;
      4'd5:  w_alu = bus.port_a & bus.port_b;
      4'd6:  w_alu = bus.port_a | bus.port_b;
      4'd7:  w_alu = bus.port_a ^ bus.port_b;
      4'd8:  w_alu = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
      4'd9:  w_alu = {{(XLEN-1){1'b0}}, (bus.port_a < bus.port_b)};
      4'd10, 4'd11, 4'd12, 4'd13: begin
`ifdef ARITH_EXEC_MUL_EN
        w_is_mul = 1'b1;
`else
        w_ill    = 1'b1;
`endif
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (bus.w_src)
      2'd0:    w_wbsel = bus.csr_rdata;
      2'd1:    w_wbsel = w_alu;
      default: w_wbsel = bus.reg_file_wdata;
    endcase
  end

  // JALR clears bit 0 of the sum; JAL target is used as-is.
  assign w_jalr_sum = bus.port_a + bus.imm_I_ext;
  assign w_target   = bus.j_sel ? (bus.pc + bus.imm_UJ_ext)
                                : {w_jalr_sum[XLEN-1:1], 1'b0};

`ifdef ARITH_EXEC_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t        r_state;
  mul_state_t        w_state_nxt;
  logic              w_mul_start;
  logic              w_last;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_mul_res;

  // {high accumulator, remaining multiplier bits}; multiplier shifts out
  // of the bottom as the accumulator shifts in from the top.
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [SHW-1:0]    r_cnt;
  logic              r_neg;
  logic              r_hi;
  logic              r_wsrc_alu_m;
  logic [XLEN-1:0]   r_alt_m;
  logic [XLEN-1:0]   r_tgt_m;
  logic [4:0]        r_rd_m;

  assign w_mul_start = w_acc && w_is_mul;
  assign w_last      = (r_cnt == SHW'(XLEN-1));
  assign w_mul_busy  = (r_state == S_RUN);
  assign w_mul_done  = (r_state == S_RUN) && w_last;

  always_ff @(posedge CLK) begin
    if (RST || bus.flush) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_mul_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign-magnitude multiply: unsigned shift-add of magnitudes, then negate
  // the full 2*XLEN product when exactly one signed operand is negative.
  assign w_a_neg = (bus.aluop != 4'd13) && bus.port_a[XLEN-1];
  assign w_b_neg = ((bus.aluop == 4'd10) || (bus.aluop == 4'd11)) && bus.port_b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~bus.port_a + 1'b1) : bus.port_a;
  assign w_b_mag = w_b_neg ? (~bus.port_b + 1'b1) : bus.port_b;

  assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
  assign w_prod_nxt = {w_sum, r_prod[XLEN-1:1]};
  assign w_prod_fin = r_neg ? (~w_prod_nxt + 1'b1) : w_prod_nxt;
  assign w_mul_res  = r_hi ? w_prod_fin[2*XLEN-1:XLEN] : w_prod_fin[XLEN-1:0];

  always_ff @(posedge CLK) begin
    if (w_mul_start) begin
      r_prod       <= {{XLEN{1'b0}}, w_b_mag};
      r_mcand      <= w_a_mag;
      r_cnt        <= '0;
      r_neg        <= w_a_neg ^ w_b_neg;
      r_hi         <= (bus.aluop != 4'd10);
      r_wsrc_alu_m <= (bus.w_src == 2'd1);
      r_alt_m      <= (bus.w_src == 2'd0) ? bus.csr_rdata : bus.reg_file_wdata;
      r_tgt_m      <= w_target;
      r_rd_m       <= bus.rd;
    end else if (r_state == S_RUN) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign w_mul_wb  = r_wsrc_alu_m ? w_mul_res : r_alt_m;
  assign w_mul_tgt = r_tgt_m;
  assign w_mul_rd  = r_rd_m;
`else
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_wb   = '0;
  assign w_mul_tgt  = '0;
  assign w_mul_rd   = '0;
`endif

  // ---- result pipeline: stage 0 captures at accept, last stage drives wb ----
  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      for (int i = 0; i < STAGES; i++) r_vld_p[i] <= 1'b0;
    end else begin
      r_vld_p[0] <= w_acc && !w_is_mul;
      for (int i = 1; i < STAGES; i++) r_vld_p[i] <= r_vld_p[i-1];
      if (w_mul_done) r_vld_p[STAGES-1] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_p[STAGES-1]   <= '0;
      r_data_p[STAGES-1] <= '0;
      r_tgt_p[STAGES-1]  <= '0;
      r_ill_p[STAGES-1]  <= 1'b0;
    end else begin
      if (w_acc && !w_is_mul) begin
        r_rd_p[0]   <= bus.rd;
        r_data_p[0] <= w_wbsel;
        r_tgt_p[0]  <= w_target;
        r_ill_p[0]  <= w_ill;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (r_vld_p[i-1]) begin
          r_rd_p[i]   <= r_rd_p[i-1];
          r_data_p[i] <= r_data_p[i-1];
          r_tgt_p[i]  <= r_tgt_p[i-1];
          r_ill_p[i]  <= r_ill_p[i-1];
        end
      end
      // The issue stall guarantees the last stage is free when this fires.
      if (w_mul_done) begin
        r_rd_p[STAGES-1]   <= w_mul_rd;
        r_data_p[STAGES-1] <= w_mul_wb;
        r_tgt_p[STAGES-1]  <= w_mul_tgt;
        r_ill_p[STAGES-1]  <= 1'b0;
      end
    end
  end

  // ---- writeback ----
  // flush kills a result sitting in the last stage in the same cycle.
  assign bus.issue_ready = w_ready;
  assign bus.wb_valid    = r_vld_p[STAGES-1] && !bus.flush && !RST;
  assign bus.wb_rd       = r_rd_p[STAGES-1];
  assign bus.wb_data     = r_data_p[STAGES-1];
  assign bus.wb_target   = r_tgt_p[STAGES-1];
  assign bus.illegal     = r_ill_p[STAGES-1];

endmodule

// File: tb/tb_arith_exec_unit.sv
module tb_arith_exec_unit;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
`ifdef ARITH_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  wsrc;
    logic [31:0] a, b, csr, rfw;
    logic [4:0]  rd;
    logic        jsel;
    logic [31:0] pc, uj, ii;
    logic [31:0] exp_data;
    logic        exp_ill;
    logic        is_mul;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] tgt;
    logic        ill;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  arith_exec_unit_if #(.XLEN(XLEN)) bus ();

  arith_exec_unit #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_target(input vec_t v);
    logic [31:0] s;
    s = v.a + v.ii;
    s[0] = 1'b0;
    return v.jsel ? (v.pc + v.uj) : s;
  endfunction

  function automatic exp_t mk_exp(input vec_t v, input int acc_cyc);
    exp_t e;
    e.rd   = v.rd;
    e.tgt  = ref_target(v);
    e.data = v.exp_data;
    e.ill  = v.exp_ill;
    e.cyc  = acc_cyc + STAGES;
    if (v.is_mul) begin
      if (MUL_EN) begin
        e.cyc = acc_cyc + XLEN + 1;
      end else begin
        e.ill  = 1'b1;
        e.data = (v.wsrc == 2'd0) ? v.csr : (v.wsrc == 2'd1) ? 32'h0 : v.rfw;
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] wsrc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] csr, input logic [31:0] rfw,
                              input logic [4:0] rd, input logic jsel,
                              input logic [31:0] pc, input logic [31:0] uj,
                              input logic [31:0] ii, input logic [31:0] ed,
                              input logic eill, input logic ismul);
    vec_t v;
    v.op = op; v.wsrc = wsrc; v.a = a; v.b = b; v.csr = csr; v.rfw = rfw;
    v.rd = rd; v.jsel = jsel; v.pc = pc; v.uj = uj; v.ii = ii;
    v.exp_data = ed; v.exp_ill = eill; v.is_mul = ismul;
    return v;
  endfunction

  // Writeback monitor: every wb_valid must match the oldest expectation.
  always @(negedge CLK) begin
    if (bus.wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got rd %0d data %h, expected no writeback (cycle %0d)",
                 bus.wb_rd, bus.wb_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd",     {27'd0, bus.wb_rd}, {27'd0, mon_e.rd});
        chk("wb_data",   bus.wb_data,        mon_e.data);
        chk("wb_target", bus.wb_target,      mon_e.tgt);
        chk("illegal",   {31'd0, bus.illegal}, {31'd0, mon_e.ill});
        chk("latency",   cyc,                mon_e.cyc);
      end
    end
  end

  task automatic issue(input vec_t v, input bit push);
    int n;
    bus.aluop          = v.op;
    bus.w_src          = v.wsrc;
    bus.port_a         = v.a;
    bus.port_b         = v.b;
    bus.csr_rdata      = v.csr;
    bus.reg_file_wdata = v.rfw;
    bus.rd             = v.rd;
    bus.j_sel          = v.jsel;
    bus.pc             = v.pc;
    bus.imm_UJ_ext     = v.uj;
    bus.imm_I_ext      = v.ii;
    bus.issue_valid    = 1'b1;
    n = 0;
    @(negedge CLK);
    while (bus.issue_ready !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (bus.issue_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: issue_ready %b after %0d cycles, expected 1", bus.issue_ready, n);
    end else if (push) begin
      sb.push_back(mk_exp(v, cyc));
    end
    @(posedge CLK);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  vec_t vm, vh, va;
  int   n;

  initial begin
    RST                = 1'b1;
    bus.issue_valid    = 1'b0;
    bus.flush          = 1'b0;
    bus.aluop          = '0;
    bus.w_src          = '0;
    bus.port_a         = '0;
    bus.port_b         = '0;
    bus.csr_rdata      = '0;
    bus.reg_file_wdata = '0;
    bus.rd             = '0;
    bus.j_sel          = 1'b0;
    bus.pc             = '0;
    bus.imm_UJ_ext     = '0;
    bus.imm_I_ext      = '0;

    //      op    ws  a             b             csr       rfw           rd jsel pc       uj            ii    exp           ill mul
    tbl.push_back(mk(4'd0,  1, 32'h7FFFFFFF, 32'h1,        0,        0,            5, 0, 0,       0,            0,    32'h80000000, 0, 0));
    tbl.push_back(mk(4'd4,  1, 32'h80000000, 32'h4,        0,        0,            6, 0, 0,       0,            0,    32'hF8000000, 0, 0));
    tbl.push_back(mk(4'd9,  1, 32'h1,        32'hFFFFFFFF, 0,        0,            7, 0, 0,       0,            0,    32'h00000001, 0, 0));
    tbl.push_back(mk(4'd1,  1, 32'h0,        32'h1,        0,        0,            8, 0, 0,       0,            0,    32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(4'd2,  1, 32'h1,        32'h23,       0,        0,            9, 0, 0,       0,            0,    32'h00000008, 0, 0));
    tbl.push_back(mk(4'd3,  1, 32'h80000000, 32'h4,        0,        0,           10, 0, 0,       0,            0,    32'h08000000, 0, 0));
    tbl.push_back(mk(4'd5,  1, 32'hF0F0F0F0, 32'hFF00FF00, 0,        0,           11, 0, 0,       0,            0,    32'hF000F000, 0, 0));
    tbl.push_back(mk(4'd6,  1, 32'hF0F0F0F0, 32'h0F0F0000, 0,        0,           12, 0, 0,       0,            0,    32'hFFFFF0F0, 0, 0));
    tbl.push_back(mk(4'd7,  1, 32'hFFFF0000, 32'h0F0F0F0F, 0,        0,           13, 0, 0,       0,            0,    32'hF0F00F0F, 0, 0));
    tbl.push_back(mk(4'd8,  1, 32'hFFFFFFFF, 32'h1,        0,        0,           14, 0, 0,       0,            0,    32'h00000001, 0, 0));
    tbl.push_back(mk(4'd8,  1, 32'h1,        32'hFFFFFFFF, 0,        0,           15, 0, 0,       0,            0,    32'h00000000, 0, 0));
    tbl.push_back(mk(4'd9,  1, 32'hFFFFFFFF, 32'h1,        0,        0,           16, 0, 0,       0,            0,    32'h00000000, 0, 0));
    tbl.push_back(mk(4'd0,  1, 32'h1003,     32'h0,        0,        0,           17, 0, 0,       0,            32'h4, 32'h00001003, 0, 0));
    tbl.push_back(mk(4'd0,  1, 32'h0,        32'h0,        0,        0,           18, 1, 32'h100, 32'hFFFFFFF0, 0,    32'h00000000, 0, 0));
    tbl.push_back(mk(4'd0,  0, 32'h5,        32'h6,        32'hABCD, 0,           19, 0, 0,       0,            0,    32'h0000ABCD, 0, 0));
    tbl.push_back(mk(4'd7,  2, 32'h5,        32'h6,        0,        32'h12345678, 20, 0, 0,       0,            0,    32'h12345678, 0, 0));
    tbl.push_back(mk(4'd0,  3, 32'h5,        32'h6,        0,        32'h87654321, 21, 0, 0,       0,            0,    32'h87654321, 0, 0));
    tbl.push_back(mk(4'd15, 1, 32'h5,        32'h6,        0,        0,           22, 0, 0,       0,            0,    32'h00000000, 1, 0));
    tbl.push_back(mk(4'd14, 0, 32'h5,        32'h6,        32'h55,   0,           23, 0, 0,       0,            0,    32'h00000055, 1, 0));
    tbl.push_back(mk(4'd10, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,        0,           24, 0, 0,       0,            0,    32'h00000001, 0, 1));
    tbl.push_back(mk(4'd11, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,        0,           25, 0, 0,       0,            0,    32'h00000000, 0, 1));
    tbl.push_back(mk(4'd13, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,        0,           26, 0, 0,       0,            0,    32'hFFFFFFFE, 0, 1));
    tbl.push_back(mk(4'd12, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,        0,           27, 0, 0,       0,            0,    32'hFFFFFFFF, 0, 1));
    tbl.push_back(mk(4'd11, 1, 32'h80000000, 32'h80000000, 0,        0,           28, 0, 0,       0,            0,    32'h40000000, 0, 1));
    tbl.push_back(mk(4'd12, 1, 32'h80000000, 32'h2,        0,        0,           29, 0, 0,       0,            0,    32'hFFFFFFFF, 0, 1));
    tbl.push_back(mk(4'd10, 1, 32'h12345678, 32'h10,       0,        0,           30, 0, 0,       0,            0,    32'h23456780, 0, 1));
    tbl.push_back(mk(4'd13, 0, 32'h3,        32'h3,        32'h77,   0,           31, 0, 0,       0,            0,    32'h00000077, 0, 1));

    // Reset behaviour
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    chk("rst_wb_valid",    {31'd0, bus.wb_valid},    32'd0);
    chk("rst_wb_data",     bus.wb_data,              32'd0);
    chk("rst_wb_target",   bus.wb_target,            32'd0);
    chk("rst_wb_rd",       {27'd0, bus.wb_rd},       32'd0);
    chk("rst_illegal",     {31'd0, bus.illegal},     32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    @(posedge CLK);
    #1;

    // Table: back-to-back issue, scoreboard checks results
    for (int i = 0; i < tbl.size(); i++) issue(tbl[i], 1'b1);
    repeat (60) @(posedge CLK);
    #1;

    // Multiply stall window
    vm = mk(4'd10, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 0, 32'h1, 0, 1);
    issue(vm, 1'b1);
    n = 0;
    @(negedge CLK);
    while (bus.issue_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("mul_ready_low_cycles", n, MUL_EN ? XLEN : 0);
    repeat (10) @(posedge CLK);
    #1;

    // Flush of an in-flight MULHU 10 cycles after accept
    vh = mk(4'd13, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 1);
    issue(vh, !MUL_EN);
    repeat (9) @(posedge CLK);
    #1;
    bus.flush = 1'b1;
    @(negedge CLK);
    chk("flush_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    chk("flush_wb_valid",    {31'd0, bus.wb_valid},    32'd0);
    @(posedge CLK);
    #1;
    bus.flush = 1'b0;
    @(negedge CLK);
    chk("after_flush_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    @(posedge CLK);
    #1;
    va = mk(4'd0, 1, 32'h10, 32'h20, 0, 0, 3, 0, 0, 0, 0, 32'h30, 0, 0);
    issue(va, 1'b1);
    repeat (50) @(posedge CLK);
    #1;

    // Flush of a single-cycle op one cycle after accept
    va = mk(4'd1, 1, 32'h50, 32'h8, 0, 0, 4, 0, 0, 0, 0, 32'h48, 0, 0);
    issue(va, 1'b0);
    bus.flush = 1'b1;
    @(posedge CLK);
    #1;
    bus.flush = 1'b0;
    repeat (6) @(posedge CLK);
    #1;

    // Reset in the middle of a multiply
    vm = mk(4'd11, 1, 32'h7, 32'h9, 0, 0, 6, 0, 0, 0, 0, 32'h0, 0, 1);
    issue(vm, !MUL_EN);
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_mul_rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    chk("mid_mul_rst_wb_data",     bus.wb_data,              32'd0);
    repeat (50) @(posedge CLK);
    #1;
    va = mk(4'd5, 1, 32'hFF, 32'h0F, 0, 0, 7, 1, 32'h200, 32'h10, 0, 32'h0F, 0, 0);
    issue(va, 1'b1);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end
endmodule
